mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/mc_alu_muldiv.sv | 66 ++++++
 rtl/mc_alu.sv | 186 ++++++++++++++++++
 tb/tb_mc_alu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state type and flag indices for mc_alu
package alu_pkg;

  localparam logic [3:0] OP_CLR  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_INC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/mc_alu_muldiv.sv
// rtl/mc_alu_muldiv.sv - iterative unsigned shift-add multiplier / restoring divider
// Outputs show the state after the pending step, so the last step's result can be captured on its own edge.
module mc_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             div_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             step,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic             div_q;
  logic [WIDTH:0]   sum, trial;
  logic [WIDTH-1:0] hi_d, lo_d;

  always_comb begin
    sum   = '0;
    trial = '0;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (div_q) begin
      // hi holds the partial remainder, lo shifts dividend bits out and quotient bits in
      trial = {hi_q, lo_q[WIDTH-1]};
      if (trial >= {1'b0, m_q}) begin
        sum  = trial - {1'b0, m_q};
        hi_d = sum[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
      {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= op_a;
      m_q   <= op_b;
      div_q <= div_sel;
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign res_lo = lo_d;
  assign res_hi = hi_d;

endmodule

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU top; MC_ALU_MULDIV_EN enables iterative mul/div
// Without MC_ALU_MULDIV_EN, mul/div opcodes decode as illegal and busy is tied low.
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alus,
  input  logic [WIDTH-1:0] ac_n,
  input  logic [WIDTH-1:0] bus_n,
  output logic [WIDTH-1:0] Dout,
  output logic [WIDTH-1:0] Dout_hi,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;

  logic [FLAG_W-1:0] flags_q;
  logic [WIDTH-1:0]  sc_lo;
  logic [FLAG_W-1:0] sc_flags;
  logic              sc_err;
  logic [WIDTH:0]    sum;
  logic              accept;
  logic              sc_accept;

  always_comb begin
    sc_lo    = '0;
    sc_flags = '0;
    sc_err   = 1'b0;
    sum      = '0;
    case (alus)
      OP_CLR: sc_lo = '0;
      OP_ADD: begin
        sum              = {1'b0, ac_n} + {1'b0, bus_n};
        sc_lo            = sum[WIDTH-1:0];
        sc_flags[FLAG_C] = sum[WIDTH];
        sc_flags[FLAG_V] = (ac_n[MSB] == bus_n[MSB]) && (sc_lo[MSB] != ac_n[MSB]);
      end
      OP_SUB: begin
        // the extra top bit of the widened difference is exactly the borrow
        sum              = {1'b0, ac_n} - {1'b0, bus_n};
        sc_lo            = sum[WIDTH-1:0];
        sc_flags[FLAG_C] = sum[WIDTH];
        sc_flags[FLAG_V] = (ac_n[MSB] != bus_n[MSB]) && (sc_lo[MSB] != ac_n[MSB]);
      end
      OP_INC: begin
        sum              = {1'b0, ac_n} + {{WIDTH{1'b0}}, 1'b1};
        sc_lo            = sum[WIDTH-1:0];
        sc_flags[FLAG_C] = sum[WIDTH];
        sc_flags[FLAG_V] = !ac_n[MSB] && sc_lo[MSB];
      end
      OP_AND:  sc_lo = ac_n & bus_n;
      OP_OR:   sc_lo = ac_n | bus_n;
      OP_NOT:  sc_lo = ~ac_n;
      OP_XOR:  sc_lo = ac_n ^ bus_n;
      OP_PASS: sc_lo = bus_n;
      OP_SHL: begin
        sc_lo            = {ac_n[MSB-1:0], 1'b0};
        sc_flags[FLAG_C] = ac_n[MSB];
      end
      OP_SHR: begin
        sc_lo            = {1'b0, ac_n[MSB:1]};
        sc_flags[FLAG_C] = ac_n[0];
      end
      default: sc_err = 1'b1;
    endcase
    if (!sc_err) begin
      sc_flags[FLAG_Z] = (sc_lo == '0);
      sc_flags[FLAG_N] = sc_lo[MSB];
    end
  end

`ifdef MC_ALU_MULDIV_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              is_md;
  logic              md_last;
  logic              op_div_q;
  logic              dz_q;
  logic [WIDTH-1:0]  md_lo, md_hi;
  logic [FLAG_W-1:0] md_flags;

  assign busy      = (state_q == RUN);
  assign accept    = start && !busy;
  assign is_md     = (alus == OP_MUL) || (alus == OP_DIV);
  assign sc_accept = accept && !is_md;
  assign md_last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FIN: state_d = (accept && is_md) ? RUN : IDLE;
      RUN:       state_d = md_last ? FIN : RUN;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == RUN && !md_last) ? cnt_q + 1'b1 : '0;
      if (accept && is_md) begin
        op_div_q <= (alus == OP_DIV);
        dz_q     <= (alus == OP_DIV) && (bus_n == '0);
      end
    end
  end

  mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && is_md),
    .div_sel (alus == OP_DIV),
    .op_a    (ac_n),
    .op_b    (bus_n),
    .step    (state_q == RUN),
    .res_lo  (md_lo),
    .res_hi  (md_hi)
  );

  always_comb begin
    md_flags = '0;
    if (op_div_q) begin
      md_flags[FLAG_Z] = (md_lo == '0);
      md_flags[FLAG_N] = md_lo[MSB];
    end else begin
      md_flags[FLAG_Z] = (md_lo == '0) && (md_hi == '0);
      md_flags[FLAG_N] = md_hi[MSB];
    end
  end
`else
  assign busy      = 1'b0;
  assign accept    = start;
  assign sc_accept = accept;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Dout    <= '0;
      Dout_hi <= '0;
      flags_q <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sc_accept) begin
        Dout    <= sc_lo;
        Dout_hi <= '0;
        flags_q <= sc_flags;
        err     <= sc_err;
        done    <= 1'b1;
      end
`ifdef MC_ALU_MULDIV_EN
      else if (md_last) begin
        Dout    <= md_lo;
        Dout_hi <= md_hi;
        flags_q <= md_flags;
        err     <= dz_q;
        done    <= 1'b1;
      end
`endif
    end
  end

  assign zf = flags_q[FLAG_Z];
  assign nf = flags_q[FLAG_N];
  assign cf = flags_q[FLAG_C];
  assign vf = flags_q[FLAG_V];

endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - directed self-checking bench for mc_alu (WIDTH=8)
module tb_mc_alu;
  import alu_pkg::*;

  logic       clk, rst_n, start;
  logic [3:0] alus;
  logic [7:0] ac_n, bus_n, Dout, Dout_hi;
  logic       zf, nf, cf, vf, err, busy, done;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  mc_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alus(alus),
    .ac_n(ac_n), .bus_n(bus_n), .Dout(Dout), .Dout_hi(Dout_hi),
    .zf(zf), .nf(nf), .cf(cf), .vf(vf), .err(err), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observed word: {done, busy, Dout, Dout_hi, zf, nf, cf, vf, err}
  function automatic logic [22:0] obs();
    return {done, busy, Dout, Dout_hi, zf, nf, cf, vf, err};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; alus = 4'h0; ac_n = 8'h00; bus_n = 8'h00;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (obs() !== 23'h0) begin
      miss_cnt++;
      $display("FAIL reset: got %h want %h", obs(), 23'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ef = {zf, nf, cf, vf, err}
  task automatic run_sc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] elo, input logic [4:0] ef);
    logic [22:0] exp_w;
    start = 1'b1; alus = op; ac_n = a; bus_n = b;
    @(negedge clk);
    start = 1'b0;
    exp_w = {1'b1, 1'b0, elo, 8'h00, ef};
    vec_cnt++;
    if (obs() !== exp_w) begin
      miss_cnt++;
      $display("FAIL op%h %h,%h: got %h want %h", op, a, b, obs(), exp_w);
    end
  endtask

  task automatic test_single();
    run_sc(OP_ADD,  8'h7F, 8'h01, 8'h80, 5'b01010);
    run_sc(OP_ADD,  8'hFF, 8'h01, 8'h00, 5'b10100);
    run_sc(OP_SUB,  8'h03, 8'h05, 8'hFE, 5'b01100);
    run_sc(OP_SUB,  8'h80, 8'h01, 8'h7F, 5'b00010);
    run_sc(OP_INC,  8'hFF, 8'h00, 8'h00, 5'b10100);
    run_sc(OP_INC,  8'h7F, 8'h00, 8'h80, 5'b01010);
    run_sc(OP_AND,  8'hF0, 8'h3C, 8'h30, 5'b00000);
    run_sc(OP_OR,   8'h0F, 8'hF0, 8'hFF, 5'b01000);
    run_sc(OP_NOT,  8'h55, 8'h00, 8'hAA, 5'b01000);
    run_sc(OP_XOR,  8'hAA, 8'hAA, 8'h00, 5'b10000);
    run_sc(OP_PASS, 8'h00, 8'h81, 8'h81, 5'b01000);
    run_sc(OP_SHL,  8'h81, 8'h00, 8'h02, 5'b00100);
    run_sc(OP_SHR,  8'h81, 8'h00, 8'h40, 5'b00100);
    run_sc(OP_CLR,  8'h12, 8'h34, 8'h00, 5'b10000);
    run_sc(4'hD,    8'h12, 8'h34, 8'h00, 5'b00001);
    run_sc(4'hE,    8'hFF, 8'hFF, 8'h00, 5'b00001);
    run_sc(4'hF,    8'h01, 8'h01, 8'h00, 5'b00001);
    run_sc(OP_ADD,  8'h01, 8'h01, 8'h02, 5'b00000);
  endtask

  task automatic test_hold();
    run_sc(OP_XOR, 8'h5A, 8'h0F, 8'h55, 5'b00000);
    ac_n = 8'hFF; bus_n = 8'hFF; alus = OP_SUB;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (obs() !== {1'b0, 1'b0, 8'h55, 8'h00, 5'b00000}) begin
      miss_cnt++;
      $display("FAIL hold: got %h want %h", obs(), {1'b0, 1'b0, 8'h55, 8'h00, 5'b00000});
    end
  endtask

`ifdef MC_ALU_MULDIV_EN
  // called at a negedge; start is raised here, so a call right after another
  // run_md issues the new start in the previous operation's done cycle
  task automatic run_md(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] elo, input logic [7:0] ehi,
                        input logic [4:0] ef, input bit poke);
    logic [22:0] exp_w;
    start = 1'b1; alus = op; ac_n = a; bus_n = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      vec_cnt++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miss_cnt++;
        $display("FAIL md_busy op%h cycle %0d: busy=%b done=%b want busy=1 done=0", op, i, busy, done);
      end
      if (poke && i == 2) begin
        start = 1'b1; alus = OP_ADD; ac_n = ~a; bus_n = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_w = {1'b1, 1'b0, elo, ehi, ef};
    vec_cnt++;
    if (obs() !== exp_w) begin
      miss_cnt++;
      $display("FAIL md op%h %h,%h: got %h want %h", op, a, b, obs(), exp_w);
    end
  endtask

  task automatic test_muldiv();
    run_md(OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b01000, 1'b1);
    run_md(OP_DIV, 8'd200, 8'd7, 8'd28, 8'd4, 5'b00000, 1'b0);
    run_md(OP_DIV, 8'd5, 8'd0, 8'hFF, 8'h05, 5'b01001, 1'b0);
    run_md(OP_MUL, 8'h00, 8'h37, 8'h00, 8'h00, 5'b10000, 1'b0);
    run_md(OP_MUL, 8'h10, 8'h10, 8'h00, 8'h01, 5'b00000, 1'b0);
  endtask

  task automatic test_reset_run();
    run_md(OP_DIV, 8'd5, 8'd0, 8'hFF, 8'h05, 5'b01001, 1'b0);
    start = 1'b1; alus = OP_MUL; ac_n = 8'h0F; bus_n = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; alus = OP_ADD; ac_n = 8'h01; bus_n = 8'h01;
    @(negedge clk);
    vec_cnt++;
    if (obs() !== 23'h0) begin
      miss_cnt++;
      $display("FAIL reset_run: got %h want %h", obs(), 23'h0);
    end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miss_cnt++;
        $display("FAIL reset_abort cycle %0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    run_sc(OP_SUB, 8'h03, 8'h05, 8'hFE, 5'b01100);
  endtask
`else
  task automatic test_nomuldiv();
    run_sc(OP_MUL, 8'hFF, 8'hFF, 8'h00, 5'b00001);
    run_sc(OP_DIV, 8'd200, 8'd7, 8'h00, 5'b00001);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miss_cnt++;
        $display("FAIL nomd_idle cycle %0d: busy=%b done=%b want 0 0", i, busy, done);
      end
    end
    run_sc(OP_SUB, 8'h03, 8'h05, 8'hFE, 5'b01100);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
`ifdef MC_ALU_MULDIV_EN
    test_muldiv();
    test_reset_run();
`else
    test_nomuldiv();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
